// File: rtl/id_stage_ctrl.sv
// rv32i decode-stage controller: classifies each fetched word, registers it into ID/EX one cycle after accept.
// A 2-entry (main + skid) buffer absorbs ex_ready stalls; serializing and illegal ops hold off intake until drain_ack.
module id_stage_ctrl #(
  parameter int unsigned PC_WIDTH          = 32,
  parameter bit          SERIALIZE_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_valid,
  input  logic [31:0]         if_ir,
  input  logic [PC_WIDTH-1:0] if_pc,
  output logic                if_ready,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [31:0]         ex_ir,
  output logic [PC_WIDTH-1:0] ex_pc,
  output logic [2:0]          ex_imm_type,
  output logic                ex_illegal,
  input  logic                flush,
  input  logic                drain_ack
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_B    = 3'b001;
  localparam logic [2:0] IMM_S    = 3'b010;
  localparam logic [2:0] IMM_U    = 3'b011;
  localparam logic [2:0] IMM_J    = 3'b100;
  localparam logic [2:0] IMM_SH   = 3'b101;
  localparam logic [2:0] IMM_Z    = 3'b110;
  localparam logic [2:0] IMM_NONE = 3'b111;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0]         ir;
    logic [PC_WIDTH-1:0] pc;
    logic [2:0]          imm_type;
    logic                illegal;
  } ent_t;

  localparam ent_t ENT_RST = '{ir: 32'h0, pc: '0, imm_type: IMM_NONE, illegal: 1'b0};

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [2:0] dec_imm;
  logic       dec_ill;
  logic       dec_ser;
  ent_t       dec_ent;

  assign opcode = if_ir[6:0];
  assign funct3 = if_ir[14:12];
  assign funct7 = if_ir[31:25];

  always_comb begin
    dec_imm = IMM_NONE;
    dec_ill = 1'b0;
    dec_ser = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: dec_imm = IMM_U;
      OPC_JAL:            dec_imm = IMM_J;
      OPC_JALR: begin
        dec_imm = IMM_I;
        dec_ill = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_imm = IMM_B;
        dec_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        dec_imm = IMM_I;
        dec_ill = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec_imm = IMM_S;
        dec_ill = funct3[2] || (funct3 == 3'b011);
      end
      OPC_OPIMM: begin
        case (funct3)
          3'b001: begin
            dec_imm = IMM_SH;
            dec_ill = (funct7 != F7_ZERO);
          end
          3'b101: begin
            dec_imm = IMM_SH;
            dec_ill = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
          end
          default: dec_imm = IMM_I;
        endcase
      end
      OPC_OP: begin
        dec_ill = !((funct7 == F7_ZERO) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_FENCE: dec_ser = 1'b1;
      OPC_SYSTEM: begin
        case (funct3)
          3'b000:                 dec_ser = 1'b1;
          3'b100:                 dec_ill = 1'b1;
          3'b101, 3'b110, 3'b111: dec_imm = IMM_Z;
          default:                dec_imm = IMM_NONE;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
    // Illegal words carry no immediate; whether they serialize is a build-time choice.
    if (dec_ill) begin
      dec_imm = IMM_NONE;
      dec_ser = SERIALIZE_ILLEGAL;
    end
  end

  assign dec_ent = '{ir: if_ir, pc: if_pc, imm_type: dec_imm, illegal: dec_ill};

  state_e state_q;
  logic   ack_q;
  logic   if_ready_q;
  logic   main_vld_q, main_vld_d;
  logic   skid_vld_q, skid_vld_d;
  ent_t   main_q, main_d;
  ent_t   skid_q, skid_d;

  logic accept;
  logic pop;
  logic main_free;
  logic enter_drain;
  logic leave_drain;

  assign accept      = if_valid && if_ready_q;
  assign pop         = main_vld_q && ex_ready;
  assign main_free   = !main_vld_q || pop;
  assign enter_drain = accept && dec_ser;
  assign leave_drain = (drain_ack || ack_q) && !main_vld_q && !skid_vld_q;

  always_comb begin
    main_vld_d = main_vld_q;
    main_d     = main_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (main_free) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = accept;
        if (accept) begin
          skid_d = dec_ent;
        end
      end else if (accept) begin
        main_d     = dec_ent;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = dec_ent;
      skid_vld_d = 1'b1;
    end
    // A redirect discards held work but leaves the last payload visible on ex_*.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= ENT_RST;
      skid_q     <= ENT_RST;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= RUN;
      ack_q      <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (enter_drain) begin
            state_q    <= DRAIN;
            if_ready_q <= 1'b0;
          end else begin
            if_ready_q <= !skid_vld_d;
          end
        end
        DRAIN: begin
          // An early drain_ack is held until the serializing op has left the buffer.
          if (leave_drain) begin
            state_q    <= RUN;
            ack_q      <= 1'b0;
            if_ready_q <= 1'b1;
          end else begin
            ack_q      <= ack_q || drain_ack;
            if_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= RUN;
          ack_q      <= 1'b0;
          if_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign if_ready    = if_ready_q;
  assign ex_valid    = main_vld_q;
  assign ex_ir       = main_q.ir;
  assign ex_pc       = main_q.pc;
  assign ex_imm_type = main_q.imm_type;
  assign ex_illegal  = main_q.illegal;

  a_no_overrun: assert property (@(posedge clk) disable iff (rst) !(accept && skid_vld_q && !main_free));

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Bench for id_stage_ctrl: queue-level reference model checked every cycle plus directed literal checks.
module tb_id_stage_ctrl;

  localparam int unsigned PW = 32;
  localparam bit          SI = 1'b1;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_valid;
  logic [31:0]   if_ir;
  logic [PW-1:0] if_pc;
  logic          if_ready;
  logic          ex_valid;
  logic          ex_ready;
  logic [31:0]   ex_ir;
  logic [PW-1:0] ex_pc;
  logic [2:0]    ex_imm_type;
  logic          ex_illegal;
  logic          flush;
  logic          drain_ack;

  int n_cmp  = 0;
  int n_fail = 0;

  id_stage_ctrl #(.PC_WIDTH(PW), .SERIALIZE_ILLEGAL(SI)) dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_ir(if_ir), .if_pc(if_pc), .if_ready(if_ready),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_ir(ex_ir), .ex_pc(ex_pc),
    .ex_imm_type(ex_imm_type), .ex_illegal(ex_illegal),
    .flush(flush), .drain_ack(drain_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Returns {imm_type, illegal, serializing} straight from the opcode table.
  function automatic logic [4:0] mdec(input logic [31:0] ir);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] imm;
    logic       ill;
    logic       ser;
    op = ir[6:0]; f3 = ir[14:12]; f7 = ir[31:25];
    imm = 3'd7; ill = 1'b0; ser = 1'b0;
    if (op == 7'h37 || op == 7'h17) imm = 3'd3;
    else if (op == 7'h6f) imm = 3'd4;
    else if (op == 7'h67) begin imm = 3'd0; ill = (f3 != 0); end
    else if (op == 7'h63) begin imm = 3'd1; ill = (f3 inside {3'd2, 3'd3}); end
    else if (op == 7'h03) begin imm = 3'd0; ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
    else if (op == 7'h23) begin imm = 3'd2; ill = (f3 > 3'd2); end
    else if (op == 7'h13) begin
      if (f3 == 3'd1) begin imm = 3'd5; ill = (f7 != 0); end
      else if (f3 == 3'd5) begin imm = 3'd5; ill = !(f7 inside {7'd0, 7'd32}); end
      else imm = 3'd0;
    end
    else if (op == 7'h33) ill = !(f7 == 0 || (f7 == 7'd32 && f3 inside {3'd0, 3'd5}));
    else if (op == 7'h0f) ser = 1'b1;
    else if (op == 7'h73) begin
      if (f3 == 0) ser = 1'b1;
      else if (f3 == 3'd4) ill = 1'b1;
      else if (f3 >= 3'd5) imm = 3'd6;
    end
    else ill = 1'b1;
    if (ill) begin imm = 3'd7; ser = SI; end
    return {imm, ill, ser};
  endfunction

  typedef struct {
    logic [31:0]   ir;
    logic [PW-1:0] pc;
    logic [2:0]    imm;
    logic          ill;
    logic          ser;
  } ment_t;

  ment_t held[$];
  bit    m_drain, m_sticky, m_rdy, m_live;

  always @(posedge clk) begin : model
    bit         acc, was_empty;
    ment_t      e;
    logic [4:0] d;
    if (rst) begin
      held.delete(); m_drain = 0; m_sticky = 0; m_rdy = 1; m_live = 1;
    end else if (flush) begin
      held.delete(); m_drain = 0; m_sticky = 0; m_rdy = 1;
    end else begin
      acc       = if_valid && m_rdy;
      was_empty = (held.size() == 0);
      e.ser     = 1'b0;
      if (!was_empty && ex_ready) void'(held.pop_front());
      if (acc) begin
        d = mdec(if_ir);
        e.ir = if_ir; e.pc = if_pc; e.imm = d[4:2]; e.ill = d[1]; e.ser = d[0];
        held.push_back(e);
      end
      if (m_drain) begin
        if ((drain_ack || m_sticky) && was_empty) begin m_drain = 0; m_sticky = 0; end
        else if (drain_ack) m_sticky = 1;
      end else if (acc && e.ser) begin
        m_drain = 1;
      end
      m_rdy = (held.size() < 2) && !m_drain;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mdl_ex_valid", ex_valid, held.size() > 0);
      check("mdl_if_ready", if_ready, m_rdy);
      if (held.size() > 0) begin
        check("mdl_ex_ir", ex_ir, held[0].ir);
        check("mdl_ex_pc", ex_pc, held[0].pc);
        check("mdl_imm_type", ex_imm_type, held[0].imm);
        check("mdl_illegal", ex_illegal, held[0].ill);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ir, input logic [PW-1:0] pc);
    if_valid = 1'b1; if_ir = ir; if_pc = pc;
    for (int k = 0; k < 20 && !if_ready; k++) cyc();
    check("send_if_ready_timeout", if_ready, 1'b1);
    cyc();
    if_valid = 1'b0;
  endtask

  task automatic dec_case(input string name, input logic [31:0] ir, input logic [PW-1:0] pc,
                          input logic [2:0] imm, input logic ill);
    send(ir, pc);
    check({name, "_valid"}, ex_valid, 1'b1);
    check({name, "_ir"}, ex_ir, ir);
    check({name, "_imm"}, ex_imm_type, imm);
    check({name, "_ill"}, ex_illegal, ill);
  endtask

  logic [31:0] st_ir  [8];
  logic [2:0]  st_imm [8];

  initial begin
    st_ir[0] = 32'h00500093; st_imm[0] = 3'b000;
    st_ir[1] = 32'h00208463; st_imm[1] = 3'b001;
    st_ir[2] = 32'h0020a223; st_imm[2] = 3'b010;
    st_ir[3] = 32'h123450b7; st_imm[3] = 3'b011;
    st_ir[4] = 32'h008000ef; st_imm[4] = 3'b100;
    st_ir[5] = 32'h00209093; st_imm[5] = 3'b101;
    st_ir[6] = 32'h3002d073; st_imm[6] = 3'b110;
    st_ir[7] = 32'h002081b3; st_imm[7] = 3'b111;

    rst = 1; if_valid = 0; if_ir = 0; if_pc = 0; ex_ready = 0; flush = 0; drain_ack = 0;
    cyc(); cyc();
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_if_ready", if_ready, 1'b1);
    check("rst_imm_type", ex_imm_type, 3'b111);
    check("rst_illegal", ex_illegal, 1'b0);
    check("rst_ex_ir", ex_ir, 32'h0);
    check("rst_ex_pc", ex_pc, 32'h0);
    rst = 0;
    cyc();

    // back-to-back stream, each visible the cycle after accept
    ex_ready = 1;
    for (int i = 0; i < 8; i++) begin
      if_valid = 1; if_ir = st_ir[i]; if_pc = 32'h100 + 32'(4 * i);
      cyc();
      check("stream_valid", ex_valid, 1'b1);
      check("stream_ir", ex_ir, st_ir[i]);
      check("stream_pc", ex_pc, 32'h100 + 32'(4 * i));
      check("stream_imm", ex_imm_type, st_imm[i]);
      check("stream_if_ready", if_ready, 1'b1);
    end
    if_valid = 0;
    cyc();
    check("stream_empty", ex_valid, 1'b0);

    // backpressure: two accepts fill main + skid, then intake stops
    ex_ready = 0;
    if_valid = 1; if_ir = 32'h00100113; if_pc = 32'h200;
    cyc();
    check("bp_a_ir", ex_ir, 32'h00100113);
    check("bp_a_rdy", if_ready, 1'b1);
    if_ir = 32'h00200193; if_pc = 32'h204;
    cyc();
    check("bp_b_rdy", if_ready, 1'b0);
    check("bp_b_stable", ex_ir, 32'h00100113);
    if_ir = 32'h00300213; if_pc = 32'h208;
    cyc();
    check("bp_c_rdy", if_ready, 1'b0);
    check("bp_c_stable", ex_ir, 32'h00100113);
    ex_ready = 1;
    cyc();
    check("bp_rel_b", ex_ir, 32'h00200193);
    check("bp_rel_rdy", if_ready, 1'b1);
    cyc();
    check("bp_rel_c", ex_ir, 32'h00300213);
    check("bp_rel_c_pc", ex_pc, 32'h208);
    if_valid = 0;
    cyc();
    check("bp_done", ex_valid, 1'b0);

    // ECALL serializes until drain_ack after EX consumes it
    ex_ready = 0;
    if_valid = 1; if_ir = 32'h00000073; if_pc = 32'h300;
    cyc();
    check("ecall_head", ex_ir, 32'h00000073);
    check("ecall_rdy", if_ready, 1'b0);
    if_ir = 32'h00500093; if_pc = 32'h304;
    cyc();
    check("ecall_hold_rdy", if_ready, 1'b0);
    check("ecall_hold_ir", ex_ir, 32'h00000073);
    ex_ready = 1;
    cyc();
    check("ecall_consumed", ex_valid, 1'b0);
    check("ecall_still_drain", if_ready, 1'b0);
    drain_ack = 1;
    cyc();
    drain_ack = 0;
    check("ecall_run_rdy", if_ready, 1'b1);
    check("ecall_no_accept", ex_valid, 1'b0);
    cyc();
    check("ecall_next_ir", ex_ir, 32'h00500093);
    if_valid = 0;
    cyc();

    // drain_ack while the ECALL is still held is remembered
    ex_ready = 0;
    if_valid = 1; if_ir = 32'h00100073; if_pc = 32'h400;
    cyc();
    if_valid = 0; drain_ack = 1;
    cyc();
    drain_ack = 0;
    check("sticky_rdy0", if_ready, 1'b0);
    check("sticky_held", ex_valid, 1'b1);
    ex_ready = 1;
    cyc();
    check("sticky_popped", ex_valid, 1'b0);
    check("sticky_rdy1", if_ready, 1'b0);
    cyc();
    check("sticky_run", if_ready, 1'b1);

    // illegal encodings
    if_valid = 1; if_ir = 32'hffffffff; if_pc = 32'h500;
    cyc();
    if_valid = 0;
    check("ill_ff_flag", ex_illegal, 1'b1);
    check("ill_ff_imm", ex_imm_type, 3'b111);
    check("ill_ff_drain", if_ready, 1'b0);
    cyc();
    drain_ack = 1;
    cyc();
    drain_ack = 0;
    check("ill_ff_run", if_ready, 1'b1);
    if_valid = 1; if_ir = 32'h02209093; if_pc = 32'h504;
    cyc();
    if_valid = 0;
    check("ill_slli_flag", ex_illegal, 1'b1);
    check("ill_slli_imm", ex_imm_type, 3'b111);
    check("ill_slli_drain", if_ready, 1'b0);
    cyc();
    drain_ack = 1;
    cyc();
    drain_ack = 0;

    // decode corners; drain_ack held high so serializing ops self-release
    drain_ack = 1;
    dec_case("lw",      32'h00002003, 32'h600, 3'b000, 1'b0);
    dec_case("ld_f3_3", 32'h00003003, 32'h604, 3'b111, 1'b1);
    dec_case("br_f3_2", 32'h00002063, 32'h608, 3'b111, 1'b1);
    dec_case("bgeu",    32'h00007063, 32'h60c, 3'b001, 1'b0);
    dec_case("jalr",    32'h00008067, 32'h610, 3'b000, 1'b0);
    dec_case("jalr_f3", 32'h00001067, 32'h614, 3'b111, 1'b1);
    dec_case("st_f3_3", 32'h00003023, 32'h618, 3'b111, 1'b1);
    dec_case("srai",    32'h40205093, 32'h61c, 3'b101, 1'b0);
    dec_case("srai_bad",32'h02205093, 32'h620, 3'b111, 1'b1);
    dec_case("sub",     32'h40208133, 32'h624, 3'b111, 1'b0);
    dec_case("op_bad",  32'h40209133, 32'h628, 3'b111, 1'b1);
    dec_case("sys_f3_4",32'h00004073, 32'h62c, 3'b111, 1'b1);
    dec_case("csrrw",   32'h30029073, 32'h630, 3'b111, 1'b0);
    dec_case("auipc",   32'h00000017, 32'h634, 3'b011, 1'b0);
    dec_case("fence",   32'h0ff0000f, 32'h638, 3'b111, 1'b0);
    dec_case("opc_zero",32'h00000000, 32'h63c, 3'b111, 1'b1);
    cyc(); cyc(); cyc();
    drain_ack = 0;
    check("dec_back_run", if_ready, 1'b1);

    // flush with skid full and DRAIN, together with drain_ack, if_valid, ex_ready
    ex_ready = 0;
    if_valid = 1; if_ir = 32'h00500093; if_pc = 32'h700;
    cyc();
    if_ir = 32'h0ff0000f; if_pc = 32'h704;
    cyc();
    check("fl_pre_rdy", if_ready, 1'b0);
    check("fl_pre_ir", ex_ir, 32'h00500093);
    flush = 1; drain_ack = 1; ex_ready = 1; if_ir = 32'h002081b3; if_pc = 32'h708;
    cyc();
    check("fl_ex_valid", ex_valid, 1'b0);
    check("fl_if_ready", if_ready, 1'b1);
    flush = 0; drain_ack = 0; if_valid = 0;
    cyc();
    check("fl_nothing", ex_valid, 1'b0);
    // flush beats a simultaneous accept
    if_valid = 1; if_ir = 32'h123450b7; if_pc = 32'h70c; flush = 1;
    cyc();
    flush = 0; if_valid = 0;
    check("fl_acc_dropped", ex_valid, 1'b0);
    check("fl_acc_rdy", if_ready, 1'b1);

    // reset mid-operation
    ex_ready = 0;
    if_valid = 1; if_ir = 32'h008000ef; if_pc = 32'h800;
    cyc();
    check("mrst_pre", ex_valid, 1'b1);
    if_valid = 0; rst = 1;
    cyc();
    rst = 0;
    check("mrst_valid", ex_valid, 1'b0);
    check("mrst_ir", ex_ir, 32'h0);
    check("mrst_pc", ex_pc, 32'h0);
    check("mrst_imm", ex_imm_type, 3'b111);
    check("mrst_rdy", if_ready, 1'b1);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_stage_ctrl.md
Name: id_stage_ctrl

Overview:
- Decode-stage controller for the rv32i core. Sits between fetch (IF) and execute (EX).
- Classifies each fetched instruction by opcode, funct3 and funct7, and produces the 3-bit imm_type that drives imm_extractor.
- Flags illegal encodings and registers the instruction into the ID/EX pipeline register under a valid/ready handshake, using a 2-entry skid buffer.
- Serializes FENCE, SYSTEM-non-CSR and illegal instructions: intake stalls until the back end acknowledges drain.

Parameters:
- PC_WIDTH, 32, width of program counter carried alongside the instruction.
- SERIALIZE_ILLEGAL, 1, when 1 illegal instructions also enter DRAIN.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- if_valid  input  1  IF presents an instruction.
- if_ir  input  32  instruction word.
- if_pc  input  PC_WIDTH  instruction address.
- if_ready  output  1  ID can accept (registered).
- ex_valid  output  1  ID/EX register holds a valid instruction.
- ex_ready  input  1  EX consumes the head this cycle.
- ex_ir  output  32  head instruction.
- ex_pc  output  PC_WIDTH  head PC.
- ex_imm_type  output  3  imm_type for imm_extractor.
- ex_illegal  output  1  head is an illegal encoding.
- flush  input  1  redirect; discard all held instructions.
- drain_ack  input  1  back end has retired the serializing instruction.

Behaviour:
- Single clock domain; reset is synchronous and active-high. Reset values: ex_valid=0, if_ready=1, ex_ir=0, ex_pc=0, ex_imm_type=3'b111, ex_illegal=0, state=RUN, skid empty.
- imm_type encoding: 000 I, 001 B, 010 S, 011 U, 100 J, 101 shamt, 110 CSR-zimm, 111 none.
- Decode (opcode → imm_type, legality):
  - 0110111 LUI and 0010111 AUIPC → 011.
  - 1101111 JAL → 100.
  - 1100111 JALR → 000; legal only when funct3=000.
  - 1100011 branch → 001; funct3 010/011 are illegal.
  - 0000011 load → 000; legal funct3 is 000, 001, 010, 100, 101.
  - 0100011 store → 010; legal funct3 is 000–010.
  - 0010011 OP-IMM → 000, except funct3 001 → 101 (requires ir[31:25]=0) and funct3 101 → 101 (requires ir[31:25] = 0000000 or 0100000).
  - 0110011 OP → 111; requires funct7 = 0000000, or 0100000 with funct3 000/101.
  - 0001111 FENCE → 111, serializing.
  - 1110011 SYSTEM: funct3 000 → 111, serializing; 001–011 → 111; 101–111 → 110; 100 is illegal.
  - Any other opcode is illegal.
  - Illegal instructions get imm_type=111 and ex_illegal=1.
- Decode is combinational on if_ir. Result, ir and pc are registered together.
- Handshake:
  - Transfer in when if_valid & if_ready. Transfer out when ex_valid & ex_ready.
  - Latency: accepted at edge N → visible on ex_* after edge N (ex_valid=1 in cycle N+1).
  - Throughput is 1 per cycle while ex_ready=1.
  - 2-entry buffer: main (ex_*) plus skid. if_ready = !skid_valid & (state==RUN), registered.
  - Accept while main is full and not draining → entry goes to skid. When main drains, skid moves to main on the same edge.
  - Order is strictly preserved. No entry is ever dropped or duplicated.
- FSM:
  - RUN → DRAIN on acceptance of a serializing instruction (FENCE, ECALL/EBREAK/xRET, or illegal when SERIALIZE_ILLEGAL=1). if_ready drops the cycle after acceptance.
  - DRAIN → RUN when drain_ack=1 and the buffer is empty. If drain_ack arrives while the instruction is still held, it is remembered (sticky) until the buffer empties.
- Flush:
  - Next edge: ex_valid=0, skid cleared, state=RUN, sticky ack cleared, if_ready=1.
  - Overrides everything, including a simultaneous accept, drain_ack or ex_ready.
- Reset mid-operation: same as flush, plus the reset output values above.
- ex_* remain stable while ex_valid & !ex_ready.

Test Plan:
- Reset → ex_valid=0, if_ready=1, ex_imm_type=111, ex_illegal=0.
- Stream with ex_ready=1 → each appears one cycle later, back-to-back, with the required imm_type:
  - ADDI 0x00500093 → 000.
  - BEQ 0x00208463 → 001.
  - SW 0x0020a223 → 010.
  - LUI 0x123450b7 → 011.
  - JAL 0x008000ef → 100.
  - SLLI 0x00209093 → 101.
  - CSRRWI 0x3002d073 → 110.
  - ADD 0x002081b3 → 111.
- Hold ex_ready=0 for 3 cycles with if_valid=1 → two accepts, then if_ready=0. ex_ir stays stable. On release the three instructions emerge in order with no loss.
- ECALL 0x00000073 → DRAIN; if_ready=0 and the next instruction is held off. drain_ack after EX consumes it → RUN, if_ready=1 the next cycle.
- Illegal instructions:
  - 0xffffffff → ex_illegal=1, imm_type=111, enters DRAIN.
  - SLLI with ir[25]=1 (0x02209093) → illegal.
- flush while skid is full and in DRAIN, asserted together with drain_ack and if_valid → next cycle ex_valid=0, if_ready=1, state RUN, no instruction accepted that cycle.
